// File: rtl/tdm_demux4_if.sv
// Bus bundle for the 1-to-4 TDM demultiplexer: stream input side plus the four channel outputs.
interface tdm_demux4_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             frame_sync;
  logic [WIDTH-1:0] ch0_out;
  logic [WIDTH-1:0] ch1_out;
  logic [WIDTH-1:0] ch2_out;
  logic [WIDTH-1:0] ch3_out;
  logic [3:0]       ch_valid;
  logic             frame_done;
  logic [1:0]       slot;
  logic             locked;
  logic             sync_err;

  modport master (
    output din, din_valid, frame_sync,
    input  ch0_out, ch1_out, ch2_out, ch3_out, ch_valid, frame_done, slot, locked, sync_err
  );

  modport slave (
    input  din, din_valid, frame_sync,
    output ch0_out, ch1_out, ch2_out, ch3_out, ch_valid, frame_done, slot, locked, sync_err
  );
endinterface

// File: rtl/tdm_demux4.sv
// Registered 1-to-4 TDM demultiplexer with HUNT/LOCKED frame tracking.
// Define TDM_DEMUX4_FRAME_HOLD_EN to present whole frames at once from shadow registers.
module tdm_demux4 #(
  parameter int unsigned WIDTH = 8
) (
  input logic          clk,
  input logic          rst_n,
  tdm_demux4_if.slave  bus
);

  typedef enum logic [0:0] {StHunt, StLocked} state_e;

  state_e           state_q, state_d;
  logic [1:0]       slot_q, slot_d;
  logic [WIDTH-1:0] ch_q [4];
  logic [WIDTH-1:0] ch_d [4];
  logic [3:0]       ch_valid_q, ch_valid_d;
  logic             frame_done_q, frame_done_d;
  logic             sync_err_q, sync_err_d;
  logic             cap_en;
  logic [1:0]       cap_idx;

  always_comb begin
    state_d    = state_q;
    slot_d     = slot_q;
    cap_en     = 1'b0;
    cap_idx    = slot_q;
    sync_err_d = 1'b0;
    unique case (state_q)
      StHunt: begin
        if (bus.din_valid && bus.frame_sync) begin
          cap_en  = 1'b1;
          cap_idx = 2'd0;
          state_d = StLocked;
        end
      end
      StLocked: begin
        if (bus.din_valid) begin
          cap_en = 1'b1;
          if (bus.frame_sync) begin
            cap_idx    = 2'd0;
            sync_err_d = (slot_q != 2'd0);
          end
        end
      end
      default: state_d = StHunt;
    endcase
    if (cap_en) slot_d = cap_idx + 2'd1;
    // Every lock and resync starts at slot 0, so reaching slot 3 always closes a full frame.
    frame_done_d = cap_en && (cap_idx == 2'd3);
  end

`ifdef TDM_DEMUX4_FRAME_HOLD_EN
  logic [WIDTH-1:0] shadow_q [3];
  logic [WIDTH-1:0] shadow_d [3];

  always_comb begin
    for (int i = 0; i < 4; i++) ch_d[i] = ch_q[i];
    for (int i = 0; i < 3; i++) shadow_d[i] = shadow_q[i];
    ch_valid_d = 4'b0000;
    if (cap_en) begin
      if (cap_idx == 2'd3) begin
        for (int i = 0; i < 3; i++) ch_d[i] = shadow_q[i];
        ch_d[3]    = bus.din;
        ch_valid_d = 4'b1111;
      end else begin
        // A resync rewrites slot 0 and the stale slots are refilled before any release.
        for (int i = 0; i < 3; i++) begin
          if (cap_idx == 2'(i)) shadow_d[i] = bus.din;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) shadow_q[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) shadow_q[i] <= shadow_d[i];
    end
  end
`else
  always_comb begin
    for (int i = 0; i < 4; i++) ch_d[i] = ch_q[i];
    ch_valid_d = 4'b0000;
    if (cap_en) begin
      ch_d[cap_idx]       = bus.din;
      ch_valid_d[cap_idx] = 1'b1;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StHunt;
      slot_q       <= 2'd0;
      ch_valid_q   <= 4'b0000;
      frame_done_q <= 1'b0;
      sync_err_q   <= 1'b0;
      for (int i = 0; i < 4; i++) ch_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      slot_q       <= slot_d;
      ch_valid_q   <= ch_valid_d;
      frame_done_q <= frame_done_d;
      sync_err_q   <= sync_err_d;
      for (int i = 0; i < 4; i++) ch_q[i] <= ch_d[i];
    end
  end

  assign bus.ch0_out    = ch_q[0];
  assign bus.ch1_out    = ch_q[1];
  assign bus.ch2_out    = ch_q[2];
  assign bus.ch3_out    = ch_q[3];
  assign bus.ch_valid   = ch_valid_q;
  assign bus.frame_done = frame_done_q;
  assign bus.slot       = slot_q;
  assign bus.locked     = (state_q == StLocked);
  assign bus.sync_err   = sync_err_q;

endmodule

// File: tb/tb_tdm_demux4.sv
// Self-checking bench for tdm_demux4: directed scenarios then random traffic against a frame model.
module tb_tdm_demux4;
  logic clk = 1'b0;
  logic rst_n;

  tdm_demux4_if #(.WIDTH(8)) bus ();

  tdm_demux4 #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: pos = -1 while hunting, otherwise the slot of the next beat.
  int         pos;
  logic [7:0] m_ch [4];
  logic [7:0] m_sh [4];
  logic [3:0] m_valid;
  logic       m_fd;
  logic       m_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    pos = -1;
    for (int i = 0; i < 4; i++) begin
      m_ch[i] = 8'h00;
      m_sh[i] = 8'h00;
    end
    m_valid = 4'h0;
    m_fd    = 1'b0;
    m_err   = 1'b0;
  endtask

  task automatic model_step(input logic [7:0] d, input logic v, input logic fs);
    int idx;
    m_valid = 4'h0;
    m_fd    = 1'b0;
    m_err   = 1'b0;
    idx     = -1;
    if (v) begin
      if (fs) begin
        if (pos > 0) m_err = 1'b1;
        idx = 0;
      end else begin
        idx = pos;
      end
    end
    if (idx >= 0) begin
      pos = (idx + 1) % 4;
      if (idx == 3) m_fd = 1'b1;
`ifdef TDM_DEMUX4_FRAME_HOLD_EN
      m_sh[idx] = d;
      if (idx == 3) begin
        for (int i = 0; i < 4; i++) m_ch[i] = m_sh[i];
        m_valid = 4'hf;
      end
`else
      m_ch[idx]    = d;
      m_valid[idx] = 1'b1;
`endif
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".ch0"}, 32'(bus.ch0_out), 32'(m_ch[0]));
    chk({tag, ".ch1"}, 32'(bus.ch1_out), 32'(m_ch[1]));
    chk({tag, ".ch2"}, 32'(bus.ch2_out), 32'(m_ch[2]));
    chk({tag, ".ch3"}, 32'(bus.ch3_out), 32'(m_ch[3]));
    chk({tag, ".ch_valid"}, 32'(bus.ch_valid), 32'(m_valid));
    chk({tag, ".frame_done"}, 32'(bus.frame_done), 32'(m_fd));
    chk({tag, ".sync_err"}, 32'(bus.sync_err), 32'(m_err));
    chk({tag, ".slot"}, 32'(bus.slot), (pos < 0) ? 32'd0 : 32'(pos));
    chk({tag, ".locked"}, 32'(bus.locked), (pos < 0) ? 32'd0 : 32'd1);
  endtask

  task automatic beat(input string tag, input logic [7:0] d, input logic v, input logic fs);
    bus.din        = d;
    bus.din_valid  = v;
    bus.frame_sync = fs;
    @(posedge clk);
    #1;
    model_step(d, v, fs);
    check_all(tag);
  endtask

  initial begin
    logic [7:0] rd;
    logic       rv;
    logic       rfs;
    rst_n          = 1'b0;
    bus.din        = 8'h00;
    bus.din_valid  = 1'b0;
    bus.frame_sync = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all("reset");
    rst_n = 1'b1;

    // Reset then lock
    beat("lock0", 8'h11, 1'b1, 1'b1);
    chk("lock0.locked_now", 32'(bus.locked), 32'd1);
    beat("lock1", 8'h22, 1'b1, 1'b0);
    beat("lock2", 8'h33, 1'b1, 1'b0);
    beat("lock3", 8'h44, 1'b1, 1'b0);
`ifndef TDM_DEMUX4_FRAME_HOLD_EN
    chk("lock.ch0_const", 32'(bus.ch0_out), 32'h11);
    chk("lock.ch3_const", 32'(bus.ch3_out), 32'h44);
    chk("lock.strobe3", 32'(bus.ch_valid), 32'h8);
`endif
    chk("lock.fd_const", 32'(bus.frame_done), 32'd1);

    // Hunt drop after a reset
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("hunt_rst");
    @(negedge clk);
    rst_n = 1'b1;
    beat("hunt_aa", 8'hAA, 1'b1, 1'b0);
    beat("hunt_bb", 8'hBB, 1'b1, 1'b0);
    beat("hunt_sync", 8'h01, 1'b1, 1'b1);
    chk("hunt.slot_const", 32'(bus.slot), 32'd1);

    // Gaps hold the frame position; frame_sync without valid is ignored
    beat("gap_55", 8'h55, 1'b1, 1'b0);
    beat("gap_idle0", 8'hEE, 1'b0, 1'b1);
    beat("gap_idle1", 8'hEE, 1'b0, 1'b0);
    beat("gap_idle2", 8'hEE, 1'b0, 1'b0);
    chk("gap.slot_hold", 32'(bus.slot), 32'd2);
    beat("gap_66", 8'h66, 1'b1, 1'b0);

    // Misplaced sync, then a normal sync at slot 0
    beat("err_77", 8'h77, 1'b1, 1'b1);
    chk("err.pulse", 32'(bus.sync_err), 32'd1);
    beat("err_after", 8'h78, 1'b1, 1'b0);
    beat("err_s2", 8'h79, 1'b1, 1'b0);
    beat("err_s3", 8'h7A, 1'b1, 1'b0);
    beat("sync_ok", 8'h7B, 1'b1, 1'b1);

    // Frame-hold scenario, also meaningful in the default build
    beat("fh_10", 8'h10, 1'b1, 1'b1);
    beat("fh_20", 8'h20, 1'b1, 1'b0);
    beat("fh_30", 8'h30, 1'b1, 1'b0);
    beat("fh_40", 8'h40, 1'b1, 1'b0);

    // Async reset between edges at slot 2
    beat("ar_0", 8'hC0, 1'b1, 1'b1);
    beat("ar_1", 8'hC1, 1'b1, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    beat("ar_drop", 8'h99, 1'b1, 1'b0);

    for (int n = 0; n < 400; n++) begin
      rd  = 8'($urandom_range(0, 255));
      rv  = ($urandom_range(0, 3) != 0);
      rfs = (pos == 0 || pos < 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 11) == 0);
      beat("rand", rd, rv, rfs);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/tdm_demux4.md
Name: tdm_demux4

Overview:
- Registered 1-to-4 time-division demultiplexer. It is the receive-side counterpart of the team's 4:1 mux.
- Accepts a slot-interleaved stream (slot 0,1,2,3,0,...) tagged by a frame-sync marker.
- Tracks the slot with a 2-bit counter and FSM, and steers each beat into one of four channel registers with per-channel valid strobes.
- Sits between a serial/TDM link and four independent single-channel consumers.

Parameters:
- WIDTH, 8, data width of the stream and of each channel output.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- din  input  WIDTH  stream data beat.
- din_valid  input  1  din carries a beat this cycle.
- frame_sync  input  1  qualified by din_valid; marks the current beat as slot 0.
- ch0_out, ch1_out, ch2_out, ch3_out  output  WIDTH  registered channel data.
- ch_valid  output  4  bit n is a one-cycle strobe meaning chn_out just updated.
- frame_done  output  1  one-cycle pulse when slot 3 of a frame has been delivered.
- slot  output  2  slot index expected for the next beat.
- locked  output  1  high in LOCKED state.
- sync_err  output  1  one-cycle pulse on a frame_sync at an unexpected slot.

Behaviour:
- Reset (rst_n=0, asynchronous): all chN_out=0, ch_valid=0, frame_done=0, slot=0, locked=0, sync_err=0, FSM=HUNT. Reset mid-frame discards partial data; no strobes until resync.
- FSM states: HUNT, LOCKED.
- HUNT:
  - Beats without frame_sync are dropped (no strobe, slot stays 0).
  - A beat with din_valid=1 and frame_sync=1 is captured as slot 0. FSM goes to LOCKED, slot becomes 1.
- LOCKED:
  - Each din_valid beat is captured into channel slot. Slot increments mod 4 (3 wraps to 0).
  - din_valid=0: nothing changes. Gaps of any length are allowed and the frame position is held.
- Resync:
  - frame_sync=1 with din_valid=1 while LOCKED and slot≠0 pulses sync_err.
  - That beat is captured as slot 0, and slot becomes 1. A partial frame gets no frame_done.
- frame_sync at slot 0 while LOCKED is normal operation, not an error.
- frame_sync with din_valid=0 is ignored in both states.
- Latency: a beat captured on edge k appears on chN_out and ch_valid[N] after edge k, one cycle. ch_valid is exactly one-hot or zero.
- frame_done: asserts in the same cycle as ch_valid[3] when slot 3 completes a frame that began with slot 0 since the last lock or resync.
- Unselected channel outputs hold their values. Outputs never return to 0 except on reset.
- locked mirrors the FSM state with registered timing.

Optional Feature:
- Macro: TDM_DEMUX4_FRAME_HOLD_EN.
- Defined: double-buffered outputs.
  - Slots 0..3 are captured into shadow registers.
  - All four chN_out update together on the cycle after slot 3 is captured.
  - ch_valid=4'b1111 for one cycle, coincident with frame_done.
  - A resync discards the shadow contents, so a partial frame is never presented.
- Undefined: per-slot update as described in Behaviour. No shadow registers are synthesized.

Test Plan:
- Reset then lock:
  - Stimulus: rst_n low for 3 cycles; then beats 0x11(sync), 0x22, 0x33, 0x44, all valid.
  - Response: locked=1 after the first beat; ch0..3_out=0x11/0x22/0x33/0x44; ch_valid strobes 0001,0010,0100,1000 on consecutive cycles; frame_done with the last beat.
- Hunt drop:
  - Stimulus: beats 0xAA, 0xBB without sync, then 0x01(sync).
  - Response: no strobes for the first two beats; ch0_out=0x01; slot=1.
- Gaps:
  - Stimulus: while locked, 0x55 valid, 3 idle cycles, 0x66 valid.
  - Response: ch1_out=0x55, then ch2_out=0x66; slot holds during the gap.
- Misplaced sync:
  - Stimulus: after slots 0 and 1, send a beat 0x77 with frame_sync.
  - Response: sync_err pulses; ch0_out=0x77; slot=1; no frame_done.
- Async reset mid-frame:
  - Stimulus: assert rst_n between clock edges at slot 2.
  - Response: all outputs go to 0 immediately with no clock edge needed; locked=0; a following unsynced beat is dropped.
- With TDM_DEMUX4_FRAME_HOLD_EN:
  - Stimulus: send frame 0x10, 0x20, 0x30, 0x40.
  - Response: outputs unchanged until one cycle after 0x40, then all four update at once; ch_valid=1111 and frame_done in the same cycle.
